// File: rtl/ula_pkg.sv
// Shared definitions for the ALU control decoder and the multicycle ALU:
// ULActl codes, FSM states and the iterative-engine operation select.
package ula_pkg;

  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SRL = 4'b0011;
  localparam logic [3:0] ULA_MUL = 4'b0100;
  localparam logic [3:0] ULA_DIV = 4'b0101;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_LUI = 4'b1000;
  localparam logic [3:0] ULA_REM = 4'b1001;
  localparam logic [3:0] ULA_NOT = 4'b1100;
  localparam logic [3:0] ULA_SLL = 4'b1110;
  localparam logic [3:0] ULA_INV = 4'b1111;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    CALC   = 2'd1,
    FIM    = 2'd2
  } estado_e;

  typedef enum logic [1:0] {
    IT_MUL = 2'd0,
    IT_DIV = 2'd1,
    IT_REM = 2'd2
  } it_op_e;

  function automatic logic eh_iterativo(input logic [3:0] codigo);
    return (codigo == ULA_MUL) || (codigo == ULA_DIV) || (codigo == ULA_REM);
  endfunction

endpackage

// File: rtl/ula_multiciclo_if.sv
// Request/response bundle between the multicycle datapath control and the ALU.
interface ula_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ULActl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] resultado;
  logic             zero;
  logic             erro;

  modport master (
    output start, ULActl, A, B,
    input  ready, done, resultado, zero, erro
  );

  modport slave (
    input  start, ULActl, A, B,
    output ready, done, resultado, zero, erro
  );
endinterface

// File: rtl/ula_iterativa.sv
// Shift-add multiplier and restoring divider sharing one accumulator,
// one operand shift register and one iteration counter.
module ula_iterativa
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  it_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fim,
  output logic [WIDTH-1:0] valor
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    cnt_r;
  it_op_e           op_r;

  logic [WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   sh_s;
  logic [WIDTH:0]   dif_s;

  // One iteration step; MSB of dif_s is the borrow of the trial subtraction
  always_comb begin
    sum_s     = {1'b0, acc_r} + {1'b0, m_r};
    sh_s      = {acc_r, q_r[WIDTH-1]};
    dif_s     = sh_s - {1'b0, m_r};
    acc_nxt_s = acc_r;
    q_nxt_s   = q_r;
    case (op_r)
      IT_MUL: begin
        if (q_r[0]) begin
          {acc_nxt_s, q_nxt_s} = {sum_s, q_r[WIDTH-1:1]};
        end else begin
          {acc_nxt_s, q_nxt_s} = {1'b0, acc_r, q_r[WIDTH-1:1]};
        end
      end
      IT_DIV, IT_REM: begin
        if (!dif_s[WIDTH]) begin
          acc_nxt_s = dif_s[WIDTH-1:0];
          q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
        end else begin
          acc_nxt_s = sh_s[WIDTH-1:0];
          q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
        end
      end
      default: begin
        acc_nxt_s = acc_r;
        q_nxt_s   = q_r;
      end
    endcase
    fim   = (cnt_r == CW'(1));
    valor = (op_r == IT_REM) ? acc_nxt_s : q_nxt_s;
  end

  // Operand latch on go, then one step per cycle until the counter empties
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
      q_r   <= '0;
      m_r   <= '0;
      cnt_r <= '0;
      op_r  <= IT_MUL;
    end else if (go) begin
      acc_r <= '0;
      q_r   <= a;
      m_r   <= b;
      cnt_r <= CW'(WIDTH);
      op_r  <= op;
    end else if (cnt_r != '0) begin
      acc_r <= acc_nxt_s;
      q_r   <= q_nxt_s;
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ula_multiciclo.sv
// Multicycle ALU: single-cycle ops register on accept, MUL/DIV/REM go
// through ula_iterativa; ready/done handshake towards the datapath control.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic              clk,
  input logic              rst,
  ula_multiciclo_if.slave  bus
);

  estado_e          estado_r;
  estado_e          estado_nxt_s;
  logic [WIDTH-1:0] resultado_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic             zero_r;
  logic             erro_r;
  logic             erro_nxt_s;

  logic [WIDTH-1:0] alu_s;
  logic             inv_s;
  logic             go_s;
  it_op_e           it_op_s;
  logic             fim_s;
  logic [WIDTH-1:0] valor_s;

  ula_iterativa #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .go    (go_s),
    .op    (it_op_s),
    .a     (bus.A),
    .b     (bus.B),
    .fim   (fim_s),
    .valor (valor_s)
  );

  // Single-cycle result and engine op select decoded from ULActl
  always_comb begin
    alu_s   = '0;
    inv_s   = 1'b0;
    it_op_s = IT_MUL;
    case (bus.ULActl)
      ULA_ADD: alu_s = bus.A + bus.B;
      ULA_SUB: alu_s = bus.A - bus.B;
      ULA_AND: alu_s = bus.A & bus.B;
      ULA_OR:  alu_s = bus.A | bus.B;
      ULA_NOT: alu_s = ~bus.A;
      ULA_SLT: alu_s = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      ULA_SLL: alu_s = bus.A << bus.B[SHW-1:0];
      ULA_SRL: alu_s = bus.A >> bus.B[SHW-1:0];
      ULA_LUI: alu_s = bus.B << (WIDTH / 2);
      ULA_MUL: it_op_s = IT_MUL;
      ULA_DIV: it_op_s = IT_DIV;
      ULA_REM: it_op_s = IT_REM;
      default: inv_s = 1'b1;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    estado_nxt_s = estado_r;
    res_nxt_s    = resultado_r;
    erro_nxt_s   = erro_r;
    go_s         = 1'b0;
    case (estado_r)
      OCIOSO: begin
        if (bus.start) begin
          erro_nxt_s = 1'b0;
          if (eh_iterativo(bus.ULActl)) begin
            // Division by zero short-circuits the engine
            if ((bus.ULActl != ULA_MUL) && (bus.B == '0)) begin
              res_nxt_s    = (bus.ULActl == ULA_DIV) ? '1 : bus.A;
              erro_nxt_s   = 1'b1;
              estado_nxt_s = FIM;
            end else begin
              go_s         = 1'b1;
              estado_nxt_s = CALC;
            end
          end else begin
            res_nxt_s    = alu_s;
            erro_nxt_s   = inv_s;
            estado_nxt_s = FIM;
          end
        end else begin
          estado_nxt_s = OCIOSO;
        end
      end
      CALC: begin
        if (fim_s) begin
          res_nxt_s    = valor_s;
          estado_nxt_s = FIM;
        end else begin
          estado_nxt_s = CALC;
        end
      end
      FIM:     estado_nxt_s = OCIOSO;
      default: estado_nxt_s = OCIOSO;
    endcase
  end

  // State and result registers; zero tracks the value being registered
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_r    <= OCIOSO;
      resultado_r <= '0;
      zero_r      <= 1'b1;
      erro_r      <= 1'b0;
    end else begin
      estado_r    <= estado_nxt_s;
      resultado_r <= res_nxt_s;
      zero_r      <= (res_nxt_s == '0);
      erro_r      <= erro_nxt_s;
    end
  end

  assign bus.ready     = (estado_r == OCIOSO);
  assign bus.done      = (estado_r == FIM);
  assign bus.resultado = resultado_r;
  assign bus.zero      = zero_r;
  assign bus.erro      = erro_r;

endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo: stimulus pushes expectations, a
// negedge monitor pops and compares on every done pulse.
module tb_ula_multiciclo;
  import ula_pkg::*;

  localparam int W = 32;

  typedef struct {
    string        nome;
    logic [W-1:0] res;
    logic         z;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ula_multiciclo_if #(.WIDTH(W)) ulai ();

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ulai)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t fila[$];
  int   erros = 0;
  int   checks = 0;
  int   dones = 0;
  int   dones_esp = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nome, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      erros++;
      $display("FAIL %s: got %h expected %h", nome, act, exp);
    end
  endtask

  // Monitor: compare every done pulse against the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst) begin
      if (prev_done) check("ready_after_done", W'(ulai.ready), W'(1));
      if (ulai.done) begin
        dones++;
        if (fila.size() == 0) begin
          check("unexpected_done", W'(ulai.done), W'(0));
        end else begin
          x = fila.pop_front();
          check({x.nome, "_res"},  ulai.resultado, x.res);
          check({x.nome, "_zero"}, W'(ulai.zero), W'(x.z));
          check({x.nome, "_erro"}, W'(ulai.erro), W'(x.e));
          check({x.nome, "_lat"},  W'(cyc - x.acc + 1), W'(x.lat));
        end
      end
      prev_done = ulai.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input string nome, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic e,
                       input int lat, input bit esperar);
    exp_t x;
    int   n;
    n = 0;
    @(negedge clk);
    while (!ulai.ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ulai.ready) begin
      check({nome, "_ready_timeout"}, W'(ulai.ready), W'(1));
      return;
    end
    ulai.start  = 1'b1;
    ulai.ULActl = op;
    ulai.A      = a;
    ulai.B      = b;
    @(posedge clk);
    x.nome = nome;
    x.res  = res;
    x.z    = (res == '0);
    x.e    = e;
    x.lat  = lat;
    x.acc  = cyc + 1;
    if (esperar) begin
      fila.push_back(x);
      dones_esp++;
    end
    @(negedge clk);
    ulai.start  = 1'b0;
    ulai.ULActl = 4'($urandom);
    ulai.A      = W'($urandom);
    ulai.B      = W'($urandom);
  endtask

  initial begin
    int n;
    ulai.start  = 1'b0;
    ulai.ULActl = 4'b0000;
    ulai.A      = '0;
    ulai.B      = '0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", W'(ulai.ready), W'(1));
    check("rst_done",  W'(ulai.done),  W'(0));
    check("rst_res",   ulai.resultado, W'(0));
    check("rst_zero",  W'(ulai.zero),  W'(1));
    check("rst_erro",  W'(ulai.erro),  W'(0));
    rst = 1'b0;

    issue("add",      ULA_ADD, 32'd7,          32'd5,          32'd12,         1'b0, 1,  1'b1);
    issue("sub",      ULA_SUB, 32'd5,          32'd5,          32'd0,          1'b0, 1,  1'b1);
    issue("slt_neg",  ULA_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1,  1'b1);
    issue("slt_pos",  ULA_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 1,  1'b1);
    issue("and",      ULA_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1,  1'b1);
    issue("or",       ULA_OR,  32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF,  1'b0, 1,  1'b1);
    issue("not",      ULA_NOT, 32'd0,          32'h1234_5678,  32'hFFFF_FFFF,  1'b0, 1,  1'b1);
    issue("srl",      ULA_SRL, 32'h8000_0000,  32'hFFFF_FFFF,  32'd1,          1'b0, 1,  1'b1);
    issue("lui",      ULA_LUI, 32'hDEAD_BEEF,  32'h0000_1234,  32'h1234_0000,  1'b0, 1,  1'b1);
    issue("add_wrap", ULA_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1,  1'b1);

    issue("mul",      ULA_MUL, 32'h0001_0000,  32'h0001_0001,  32'h0001_0000,  1'b0, 33, 1'b1);
    repeat (4) @(negedge clk);
    ulai.start  = 1'b1;
    ulai.ULActl = ULA_ADD;
    ulai.A      = 32'd1;
    ulai.B      = 32'd1;
    repeat (3) @(negedge clk);
    ulai.start  = 1'b0;

    issue("mul_max",  ULA_MUL, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 33, 1'b1);
    issue("div",      ULA_DIV, 32'd100,        32'd7,          32'd14,         1'b0, 33, 1'b1);
    issue("rem",      ULA_REM, 32'd100,        32'd7,          32'd2,          1'b0, 33, 1'b1);
    issue("div0",     ULA_DIV, 32'd9,          32'd0,          32'hFFFF_FFFF,  1'b1, 1,  1'b1);
    issue("rem0",     ULA_REM, 32'd9,          32'd0,          32'd9,          1'b1, 1,  1'b1);
    issue("inv1010",  4'b1010, 32'd3,          32'd4,          32'd0,          1'b1, 1,  1'b1);
    issue("inv1111",  ULA_INV, 32'd3,          32'd4,          32'd0,          1'b1, 1,  1'b1);
    issue("erro_clr", ULA_ADD, 32'd1,          32'd1,          32'd2,          1'b0, 1,  1'b1);

    issue("div_abort", ULA_DIV, 32'd100,       32'd7,          32'd0,          1'b0, 0,  1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", W'(ulai.ready), W'(1));
    check("abort_done",  W'(ulai.done),  W'(0));
    check("abort_res",   ulai.resultado, W'(0));
    check("abort_zero",  W'(ulai.zero),  W'(1));
    rst = 1'b0;

    issue("sll",      ULA_SLL, 32'd1,          32'h0000_0024,  32'h0000_0010,  1'b0, 1,  1'b1);
    repeat (40) @(negedge clk);

    n = 0;
    while (fila.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", W'(fila.size()), W'(0));
    check("done_count",  W'(dones),       W'(dones_esp));

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", erros, checks);
    $fatal(1, "watchdog");
  end

endmodule
